pl_mem_lsu: RTL and testbench
=============================

# pl_mem_lsu

Memory-stage load/store unit for the pipelined RISC-V core. It consumes the execute→memory pipeline register outputs: address, store data, access type, and request strobes. It runs each load or store as a multi-cycle valid/ready transaction on the data-memory bus, formats byte, half and word data, and returns a stall to freeze the EM register while an access is outstanding. Loaded data is delivered to the writeback path with sign or zero extension applied.

## Interface
- TIMEOUT, 255: maximum BUSY cycles waiting for `dmem_ready` before the access is abandoned with a bus error (range 1..65535).
- clk  in  1  pipeline clock, all state on rising edge
- rst_n  in  1  asynchronous, active-low reset
- MemReqM  in  1  M-stage instruction is a load or store
- MemWriteM  in  1  1 = store, 0 = load
- Funct3M  in  3  access type (RV32I load/store funct3)
- ALUResultM  in  32  byte address
- WriteDataM  in  32  store source register value
- StallM  out  1  freeze EM register and upstream stages (drives EM `en`)
- ReadDataM  out  32  formatted load result, held until the next load completes
- LoadDoneM  out  1  one-cycle pulse, ReadDataM updated this cycle
- MisalignM  out  1  combinational, misaligned or illegal access (no bus cycle)
- BusErrM  out  1  one-cycle pulse, access timed out
- dmem_req  out  1  bus request
- dmem_we  out  1  bus write enable
- dmem_addr  out  32  word address ({addr[31:2],2'b00})
- dmem_wdata  out  32  lane-replicated store data
- dmem_be  out  4  byte enables (all 1 for loads)
- dmem_ready  in  1  bus accepts/completes the current request
- dmem_rdata  in  32  read data, valid with dmem_ready on loads

## Operation
- FSM states: IDLE, BUSY, DONE. Reset → IDLE. All registered outputs reset to 0.
- IDLE:
  - If MemReqM and the access is legal, latch address, we, be, wdata, funct3 and offset (addr[1:0]), then go to BUSY.
  - StallM = 1 combinationally in this cycle.
- BUSY:
  - dmem_req = 1; addr, we, be and wdata are registered and stable until ready.
  - Wait counter increments each cycle.
  - dmem_ready sampled high → capture formatted rdata for a load, go to DONE.
  - Counter reaches TIMEOUT with no ready → drop req, go to DONE with BusErrM.
  - StallM = 1.
- DONE:
  - StallM = 0, so the EM register advances at the next edge.
  - LoadDoneM pulses for a completed load; BusErrM pulses on timeout.
  - Next state is always IDLE.
- Legal funct3:
  - Loads: 000 LB, 001 LH, 010 LW, 100 LBU, 101 LHU.
  - Stores: 000 SB, 001 SH, 010 SW.
  - Any other funct3, LH/LHU/SH with addr[0]=1, or LW/SW with addr[1:0]≠0 → MisalignM = 1. No stall, no bus cycle, ReadDataM unchanged.
- Store formatting:
  - SB: wdata = {4{WriteDataM[7:0]}}, be = 4'b0001 << offset.
  - SH: wdata = {2{WriteDataM[15:0]}}, be = 4'b0011 << offset.
  - SW: wdata = WriteDataM, be = 4'b1111.
- Load formatting:
  - shifted = dmem_rdata >> (8*offset).
  - LB/LH sign-extend bit 7 or bit 15; LBU/LHU zero-extend; LW passes shifted through.
- An issued bus transaction is never abandoned except on timeout. Inputs are ignored outside IDLE.

## Timing
- Zero-wait access (ready in the first BUSY cycle) takes 3 cycles: IDLE accept, BUSY, DONE. StallM is high for 2 cycles.
- Each additional wait cycle adds one stall cycle.
- ReadDataM updates on the edge entering DONE and is valid while LoadDoneM is high.
- Back-to-back memory instructions: the next access is accepted in the IDLE cycle immediately after DONE. There is no bubble beyond that cycle.
- dmem_req rises on the edge entering BUSY and falls on the edge leaving BUSY. It never deasserts without dmem_ready except on timeout.
- rst_n low at any point, including mid-BUSY: dmem_req, StallM and all pulses go to 0 immediately and the FSM returns to IDLE. The pending bus cycle is abandoned.

## Structure
- Package `pl_lsu_pkg` holds:
  - funct3 localparams (F3_B, F3_H, F3_W, F3_BU, F3_HU).
  - FSM state encoding.
  - TIMEOUT default.
- Sub-module `pl_lsu_align` (combinational) holds:
  - legality check and byte-enable/store-data generation.
  - load extraction and extension.
  - top-level `pl_mem_lsu` contains only the FSM, wait counter and output registers.

## Test plan
- SW 0xDEADBEEF to addr 0x100, ready on first BUSY cycle:
  - dmem_addr=0x100, be=1111, wdata=0xDEADBEEF.
  - StallM high for exactly 2 cycles.
- LB from addr 0x103, rdata=0x80FF_FF00 → ReadDataM=0xFFFFFF80 with LoadDoneM pulse.
- LBU from the same address and data → ReadDataM=0x00000080.
- SH of 0x1234 at 0x102:
  - be=1100, wdata=0x12341234.
  - ready delayed 4 cycles → StallM high for 6 cycles.
- LW at 0x101 → MisalignM=1, StallM=0, dmem_req never asserted.
- LW with ready never asserted, TIMEOUT=8:
  - BusErrM pulses after 8 BUSY cycles, then the FSM returns to IDLE.
  - A separate run with rst_n pulsed low mid-BUSY drops dmem_req and StallM immediately.

Source files
------------

// File: rtl/pl_lsu_pkg.sv
// Shared definitions for the memory-stage load/store unit.
package pl_lsu_pkg;

    // RV32I load/store funct3 encodings
    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

    // Default number of BUSY cycles allowed before a bus error
    localparam int TIMEOUT_DEF = 255;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_BUSY = 2'd1,
        S_DONE = 2'd2
    } lsu_state_e;

endpackage

// File: rtl/pl_lsu_align.sv
// Combinational access formatting: legality, store lanes/enables, load extraction.
module pl_lsu_align
    import pl_lsu_pkg::*;
(
    input  logic        we,
    input  logic [2:0]  funct3,
    input  logic [1:0]  addr_lo,
    input  logic [31:0] src,
    output logic        legal,
    output logic [3:0]  be,
    output logic [31:0] wdata,
    input  logic [2:0]  ld_funct3,
    input  logic [1:0]  ld_off,
    input  logic [31:0] rdata,
    output logic [31:0] ld_data
);

    logic [31:0] shifted;

    // Loads pick the addressed byte/half down to bit 0 before extension
    assign shifted = rdata >> {ld_off, 3'b000};

    // Legality plus store lane replication; loads always enable all four bytes
    always_comb begin
        legal = 1'b0;
        be    = 4'b1111;
        wdata = src;
        case (funct3)
            F3_B: begin
                legal = 1'b1;
                if (we) begin
                    be    = 4'b0001 << addr_lo;
                    wdata = {4{src[7:0]}};
                end
            end
            F3_H: begin
                legal = !addr_lo[0];
                if (we) begin
                    be    = 4'b0011 << addr_lo;
                    wdata = {2{src[15:0]}};
                end
            end
            F3_W:    legal = (addr_lo == 2'b00);
            F3_BU:   legal = !we;
            F3_HU:   legal = !we && !addr_lo[0];
            default: legal = 1'b0;
        endcase
    end

    // Sign- or zero-extend the extracted load value
    always_comb begin
        case (ld_funct3)
            F3_B:    ld_data = {{24{shifted[7]}}, shifted[7:0]};
            F3_H:    ld_data = {{16{shifted[15]}}, shifted[15:0]};
            F3_BU:   ld_data = {24'h0, shifted[7:0]};
            F3_HU:   ld_data = {16'h0, shifted[15:0]};
            default: ld_data = shifted;
        endcase
    end

endmodule

// File: rtl/pl_mem_lsu.sv
// Memory-stage load/store unit: one bus transaction per legal access, stalls EM meanwhile.
module pl_mem_lsu
    import pl_lsu_pkg::*;
#(
    parameter int TIMEOUT = TIMEOUT_DEF
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        MemReqM,
    input  logic        MemWriteM,
    input  logic [2:0]  Funct3M,
    input  logic [31:0] ALUResultM,
    input  logic [31:0] WriteDataM,
    output logic        StallM,
    output logic [31:0] ReadDataM,
    output logic        LoadDoneM,
    output logic        MisalignM,
    output logic        BusErrM,
    output logic        dmem_req,
    output logic        dmem_we,
    output logic [31:0] dmem_addr,
    output logic [31:0] dmem_wdata,
    output logic [3:0]  dmem_be,
    input  logic        dmem_ready,
    input  logic [31:0] dmem_rdata
);

    lsu_state_e  state, state_nxt;
    logic [15:0] wait_cnt;
    logic [2:0]  f3_q;
    logic [1:0]  off_q;
    logic        legal, accept, timeout_hit, ld_fire;
    logic [3:0]  be_fmt;
    logic [31:0] wdata_fmt, ld_data;

    pl_lsu_align u_align (
        .we        (MemWriteM),
        .funct3    (Funct3M),
        .addr_lo   (ALUResultM[1:0]),
        .src       (WriteDataM),
        .legal     (legal),
        .be        (be_fmt),
        .wdata     (wdata_fmt),
        .ld_funct3 (f3_q),
        .ld_off    (off_q),
        .rdata     (dmem_rdata),
        .ld_data   (ld_data)
    );

    assign accept      = (state == S_IDLE) && MemReqM && legal;
    assign timeout_hit = (state == S_BUSY) && !dmem_ready && (wait_cnt == 16'(TIMEOUT - 1));
    assign ld_fire     = (state == S_BUSY) && dmem_ready && !dmem_we;

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= S_IDLE;
        else        state <= state_nxt;
    end

    // Next-state logic; DONE always falls back to IDLE so the next access is taken there
    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE:  if (accept) state_nxt = S_BUSY;
            S_BUSY:  if (dmem_ready || timeout_hit) state_nxt = S_DONE;
            S_DONE:  state_nxt = S_IDLE;
            default: state_nxt = S_IDLE;
        endcase
    end

    // Combinational outputs; rst_n gating forces stall/misalign low during reset
    always_comb begin
        StallM    = rst_n && (accept || (state == S_BUSY));
        MisalignM = rst_n && (state == S_IDLE) && MemReqM && !legal;
        dmem_req  = (state == S_BUSY);
    end

    // Latch the formatted request on accept; held stable through BUSY
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            dmem_addr  <= '0;
            dmem_we    <= 1'b0;
            dmem_be    <= '0;
            dmem_wdata <= '0;
            f3_q       <= '0;
            off_q      <= '0;
        end else if (accept) begin
            dmem_addr  <= {ALUResultM[31:2], 2'b00};
            dmem_we    <= MemWriteM;
            dmem_be    <= be_fmt;
            dmem_wdata <= wdata_fmt;
            f3_q       <= Funct3M;
            off_q      <= ALUResultM[1:0];
        end
    end

    // Count BUSY cycles spent waiting for ready
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)                 wait_cnt <= '0;
        else if (accept)            wait_cnt <= '0;
        else if (state == S_BUSY)   wait_cnt <= wait_cnt + 16'd1;
    end

    // Completion pulses and load result, all visible during DONE
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ReadDataM <= '0;
            LoadDoneM <= 1'b0;
            BusErrM   <= 1'b0;
        end else begin
            LoadDoneM <= ld_fire;
            BusErrM   <= timeout_hit;
            if (ld_fire) ReadDataM <= ld_data;
        end
    end

endmodule

// File: tb/tb_pl_mem_lsu.sv
// Randomized self-checking bench for pl_mem_lsu against an arithmetic reference model.
module tb_pl_mem_lsu;

    localparam int TO = 8;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        MemReqM = 1'b0, MemWriteM = 1'b0;
    logic [2:0]  Funct3M = '0;
    logic [31:0] ALUResultM = '0, WriteDataM = '0;
    logic        StallM, LoadDoneM, MisalignM, BusErrM;
    logic [31:0] ReadDataM;
    logic        dmem_req, dmem_we;
    logic [31:0] dmem_addr, dmem_wdata;
    logic [3:0]  dmem_be;
    logic        dmem_ready = 1'b0;
    logic [31:0] dmem_rdata = '0;

    int          n_chk = 0;
    int          n_pass = 0;
    logic [31:0] last_rd = '0;

    pl_mem_lsu #(.TIMEOUT(TO)) dut (
        .clk(clk), .rst_n(rst_n), .MemReqM(MemReqM), .MemWriteM(MemWriteM),
        .Funct3M(Funct3M), .ALUResultM(ALUResultM), .WriteDataM(WriteDataM),
        .StallM(StallM), .ReadDataM(ReadDataM), .LoadDoneM(LoadDoneM),
        .MisalignM(MisalignM), .BusErrM(BusErrM), .dmem_req(dmem_req),
        .dmem_we(dmem_we), .dmem_addr(dmem_addr), .dmem_wdata(dmem_wdata),
        .dmem_be(dmem_be), .dmem_ready(dmem_ready), .dmem_rdata(dmem_rdata)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", tag, got, exp);
    endtask

    // Reference model: access size from funct3, natural alignment required
    function automatic bit m_legal(input bit we, input logic [2:0] f3, input logic [31:0] a);
        int sz;
        if (we && f3 > 3'd2) return 1'b0;
        if (!we && !(f3 inside {3'd0, 3'd1, 3'd2, 3'd4, 3'd5})) return 1'b0;
        sz = 1 << int'(f3 & 3'd3);
        return (a % sz) == 0;
    endfunction

    function automatic logic [3:0] m_be(input bit we, input logic [2:0] f3, input logic [31:0] a);
        int off;
        off = int'(a % 4);
        if (!we || f3 == 3'd2) return 4'hF;
        if (f3 == 3'd0) return 4'(1 << off);
        return 4'(3 << off);
    endfunction

    function automatic logic [31:0] m_wdata(input logic [2:0] f3, input logic [31:0] d);
        if (f3 == 3'd0) return (d & 32'hFF) * 32'h0101_0101;
        if (f3 == 3'd1) return (d & 32'hFFFF) * 32'h0001_0001;
        return d;
    endfunction

    function automatic logic [31:0] m_load(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] rd);
        logic [31:0] v;
        longint      x;
        v = rd >> (8 * (a % 4));
        case (f3)
            3'd0: begin x = v & 32'hFF;   if (x >= 128)   x = x - 256;   end
            3'd1: begin x = v & 32'hFFFF; if (x >= 32768) x = x - 65536; end
            3'd4: x = v & 32'hFF;
            3'd5: x = v & 32'hFFFF;
            default: x = v;
        endcase
        return 32'(x);
    endfunction

    // One access; delay = BUSY cycles before ready, negative = ready never comes
    task automatic access(input bit we, input logic [2:0] f3, input logic [31:0] a,
                          input logic [31:0] d, input logic [31:0] rd, input int delay);
        int cyc, busy, stalls;
        bit done, lg;
        lg = m_legal(we, f3, a);
        @(negedge clk);
        MemReqM = 1'b1; MemWriteM = we; Funct3M = f3; ALUResultM = a; WriteDataM = d;
        dmem_ready = 1'b0;
        #1;
        chk("pulse_clear", {30'h0, LoadDoneM, BusErrM}, 32'h0);
        if (!lg) begin
            chk("misalign", MisalignM, 1);
            chk("mis_stall", StallM, 0);
            @(negedge clk); #1;
            chk("mis_req", dmem_req, 0);
            chk("mis_rd_hold", ReadDataM, last_rd);
            MemReqM = 1'b0;
            return;
        end
        chk("misalign_lo", MisalignM, 0);
        cyc = 0; busy = 0; stalls = 0; done = 1'b0;
        while (!done && cyc < 400) begin
            if (StallM) stalls++;
            if (dmem_req) begin
                if (busy == 0) begin
                    chk("addr", dmem_addr, {a[31:2], 2'b00});
                    chk("we", dmem_we, we);
                    chk("be", dmem_be, m_be(we, f3, a));
                    if (we) chk("wdata", dmem_wdata, m_wdata(f3, d));
                end
                dmem_ready = (busy == delay);
                dmem_rdata = (busy == delay) ? rd : $urandom;
                busy++;
            end else begin
                dmem_ready = 1'b0;
                if (cyc > 0) begin
                    done = 1'b1;
                    chk("stall_cycles", stalls, (delay < 0) ? TO + 1 : delay + 2);
                    chk("busy_cycles", busy, (delay < 0) ? TO : delay + 1);
                    chk("load_done", LoadDoneM, (!we && delay >= 0));
                    chk("bus_err", BusErrM, (delay < 0));
                    if (!we && delay >= 0) last_rd = m_load(f3, a, rd);
                    chk("read_data", ReadDataM, last_rd);
                end
            end
            if (!done) begin
                @(negedge clk); #1;
                cyc++;
            end
        end
        if (!done) chk("access_bound", 0, 1);
    endtask

    initial begin
        bit          we;
        logic [2:0]  f3;
        logic [2:0]  legal_ld [5];
        int          dly;
        legal_ld = '{3'd0, 3'd1, 3'd2, 3'd4, 3'd5};

        #1;
        chk("rst_stall", StallM, 0);
        chk("rst_req", dmem_req, 0);
        chk("rst_rd", ReadDataM, 0);
        chk("rst_pulses", {30'h0, LoadDoneM, BusErrM}, 0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;

        // Directed cases
        access(1'b1, 3'd2, 32'h100, 32'hDEADBEEF, 32'h0, 0);
        access(1'b0, 3'd0, 32'h103, 32'h0, 32'h80FF_FF00, 0);
        chk("lb_value", ReadDataM, 32'hFFFF_FF80);
        access(1'b0, 3'd4, 32'h103, 32'h0, 32'h80FF_FF00, 0);
        chk("lbu_value", ReadDataM, 32'h0000_0080);
        access(1'b1, 3'd1, 32'h102, 32'h0000_1234, 32'h0, 4);
        access(1'b0, 3'd2, 32'h101, 32'h0, 32'h0, 0);
        access(1'b0, 3'd2, 32'h104, 32'h0, 32'h0, -1);
        @(negedge clk); #1;
        chk("after_to_idle_req", dmem_req, 0);

        // Reset in the middle of BUSY
        MemReqM = 1'b1; MemWriteM = 1'b0; Funct3M = 3'd2; ALUResultM = 32'h200;
        @(negedge clk); #1;
        chk("rst_mid_busy", dmem_req, 1);
        #2 rst_n = 1'b0;
        #1;
        chk("rst_mid_req", dmem_req, 0);
        chk("rst_mid_stall", StallM, 0);
        @(negedge clk);
        MemReqM = 1'b0;
        rst_n = 1'b1;
        last_rd = '0;
        #1;
        chk("rst_mid_rd", ReadDataM, 0);

        // Randomized traffic, mostly legal, some timeouts and idle gaps
        for (int i = 0; i < 60; i++) begin
            we = 1'($urandom_range(0, 1));
            if ($urandom_range(0, 3) == 0) f3 = 3'($urandom_range(0, 7));
            else if (we)                   f3 = 3'($urandom_range(0, 2));
            else                           f3 = legal_ld[$urandom_range(0, 4)];
            dly = ($urandom_range(0, 9) == 0) ? -1 : int'($urandom_range(0, 4));
            access(we, f3, $urandom, $urandom, $urandom, dly);
            if ($urandom_range(0, 2) == 0) begin
                @(negedge clk);
                MemReqM = 1'b0;
            end
        end

        @(negedge clk);
        MemReqM = 1'b0;
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
